// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch stage with a prefetch FIFO. Issues ROM reads on its own,
// tracks requests in flight for ROM_LAT cycles, buffers returned instructions
// in a DEPTH-entry show-ahead FIFO and hands them to ID over valid/ready.
// A flush redirects fetch and discards everything buffered or in flight.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   rom_ce_o    ROM request this cycle
//   rom_addr_o  ROM address (meaningful when rom_ce_o=1)
//   rom_data_i  ROM data, valid ROM_LAT cycles after the request
//   flush_i     redirect fetch, drop buffered and in-flight instructions
//   new_pc_i    redirect target (word-aligned internally)
//   id_valid_o  FIFO head valid
//   id_pc_o     PC of head instruction (0 when empty)
//   id_inst_o   head instruction (0 when empty)
//   id_ready_i  ID accepts the head this cycle
// -----------------------------------------------------------------------------
module if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i
);

  localparam int PW = $clog2(DEPTH);
  // wide enough for count + in-flight, which never exceeds DEPTH
  localparam int CW = $clog2(DEPTH + ROM_LAT + 1);

  logic                run_q;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ROM_LAT-1:0]  slot_v_q, slot_v_d;
  logic [ADDR_W-1:0]   slot_pc_q [ROM_LAT];
  logic [ADDR_W-1:0]   slot_pc_d [ROM_LAT];
  logic [ADDR_W-1:0]   mem_pc_q   [DEPTH];
  logic [INST_W-1:0]   mem_inst_q [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       inflight;
  logic [CW:0]         used, limit;
  logic                pop_raw, pop, push, issue;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = ^new_pc_i[1:0];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + CW'(slot_v_q[i]);
    end
  end

  assign id_valid_o = (count_q != '0);
  assign id_pc_o    = id_valid_o ? mem_pc_q[rd_ptr_q]   : '0;
  assign id_inst_o  = id_valid_o ? mem_inst_q[rd_ptr_q] : '0;

  assign pop_raw = id_valid_o & id_ready_i;
  assign pop     = pop_raw & ~flush_i;
  // the oldest slot's data arrives this cycle; a flush throws it away
  assign push    = slot_v_q[ROM_LAT-1] & ~flush_i;

  // credit rule: count + inflight - pop < DEPTH, rearranged to avoid underflow
  assign used  = {1'b0, count_q} + {1'b0, inflight};
  assign limit = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop_raw};
  assign issue = run_q & ~flush_i & (used < limit);

  assign rom_ce_o   = issue;
  assign rom_addr_o = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush_i) begin
      fetch_pc_d = {new_pc_i[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
  end

  always_comb begin
    slot_v_d     = slot_v_q;
    slot_v_d[0]  = issue;
    slot_pc_d    = slot_pc_q;
    slot_pc_d[0] = fetch_pc_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      slot_v_d[i]  = slot_v_q[i-1];
      slot_pc_d[i] = slot_pc_q[i-1];
    end
    if (flush_i) begin
      slot_v_d = '0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      slot_v_q   <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        slot_pc_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      // holds issue off for the cycle in which reset is released
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      slot_v_q   <= slot_v_d;
      slot_pc_q  <= slot_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // storage needs no reset: entries are only visible through count_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= slot_pc_q[ROM_LAT-1];
      mem_inst_q[wr_ptr_q] <= rom_data_i;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        ready_x, flush_x;
  logic [31:0] newpc_x;

  logic        ce_a, ce_b, valid_a, valid_b;
  logic [31:0] addr_a, addr_b, pc_a, pc_b, inst_a, inst_b;
  logic [31:0] rd_a, rb1, rd_b;
  logic        flush_a, flush_b, ready_a, ready_b;

  assign flush_a = flush_x & ~sel;
  assign ready_a = ready_x & ~sel;
  assign flush_b = flush_x & sel;
  assign ready_b = ready_x & sel;

  if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .ROM_LAT(1), .RESET_PC(32'h0)) u_lat1 (
    .clk(clk), .rst(rst), .rom_ce_o(ce_a), .rom_addr_o(addr_a), .rom_data_i(rd_a),
    .flush_i(flush_a), .new_pc_i(newpc_x), .id_valid_o(valid_a), .id_pc_o(pc_a),
    .id_inst_o(inst_a), .id_ready_i(ready_a));

  if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .ROM_LAT(2), .RESET_PC(32'h0)) u_lat2 (
    .clk(clk), .rst(rst), .rom_ce_o(ce_b), .rom_addr_o(addr_b), .rom_data_i(rd_b),
    .flush_i(flush_b), .new_pc_i(newpc_x), .id_valid_o(valid_b), .id_pc_o(pc_b),
    .id_inst_o(inst_b), .id_ready_i(ready_b));

  logic        obs_ce, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_inst;
  assign obs_ce    = sel ? ce_b    : ce_a;
  assign obs_addr  = sel ? addr_b  : addr_a;
  assign obs_valid = sel ? valid_b : valid_a;
  assign obs_pc    = sel ? pc_b    : pc_a;
  assign obs_inst  = sel ? inst_b  : inst_a;

  function automatic logic [31:0] romf(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // ROM models; garbage when no request so stale captures show up
  always @(posedge clk) begin
    rd_a <= ce_a ? romf(addr_a) : 32'hDEAD_BEEF;
    rb1  <= ce_b ? romf(addr_b) : 32'hDEAD_BEEF;
    rd_b <= rb1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every issued request becomes an expected entry that may
  // reach the head at cycle issue+ROM_LAT+1
  typedef struct {
    logic [31:0] pc;
    int          avail;
  } ent_t;

  ent_t        q[$];
  logic [31:0] popped[$];
  logic [31:0] mpc;
  logic        mrun;
  int          cyc;
  int          dut_issues;
  int          first_dut_valid;

  always @(negedge clk) begin
    int   lat;
    logic hr, dopop, expce;
    if (!rst) begin
      q.delete();
      mpc = 32'h0;
      mrun = 1'b0;
      cyc = 0;
      dut_issues = 0;
      first_dut_valid = -1;
    end else begin
      lat = sel ? 2 : 1;
      hr = (q.size() > 0) && (q[0].avail <= cyc);
      check("id_valid", {31'b0, obs_valid}, {31'b0, hr});
      if (hr) begin
        check("id_pc", obs_pc, q[0].pc);
        check("id_inst", obs_inst, romf(q[0].pc));
      end else begin
        check("id_pc_idle", obs_pc, 32'h0);
        check("id_inst_idle", obs_inst, 32'h0);
      end
      if (obs_valid && first_dut_valid < 0) first_dut_valid = cyc;
      if (obs_valid && ready_x && !flush_x) popped.push_back(obs_pc);
      dopop = hr && ready_x && !flush_x;
      expce = mrun && !flush_x && ((q.size() - (dopop ? 1 : 0)) < DEPTH);
      check("rom_ce", {31'b0, obs_ce}, {31'b0, expce});
      if (obs_ce) dut_issues++;
      if (obs_ce && expce) check("rom_addr", obs_addr, mpc);
      if (dopop) void'(q.pop_front());
      if (flush_x) begin
        q.delete();
        mpc = {newpc_x[31:2], 2'b00};
      end else if (expce) begin
        q.push_back('{pc: mpc, avail: cyc + lat + 1});
        mpc = mpc + 32'd4;
      end
      mrun = 1'b1;
      cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic s, input logic rdy);
    rst = 1'b0;
    sel = s;
    ready_x = rdy;
    flush_x = 1'b0;
    idle(2);
    rst = 1'b1;
    popped.delete();
  endtask

  task automatic flush_to(input logic [31:0] t);
    @(posedge clk);
    #1;
    flush_x = 1'b1;
    newpc_x = t;
    popped.delete();
    @(posedge clk);
    #1;
    flush_x = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    for (int k = 0; k < 80 && popped.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
    check("pop_timeout", {31'b0, popped.size() >= n}, 32'h1);
  endtask

  task automatic check_pops(input string name, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < popped.size()) check(name, popped[i], base + 32'(4 * i));
    end
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_pc [4];
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{target: 32'h0000_0200, exp_pc: '{32'h200, 32'h204, 32'h208, 32'h20C}};
    vecs[1] = '{target: 32'h0000_0043, exp_pc: '{32'h40, 32'h44, 32'h48, 32'h4C}};
    vecs[2] = '{target: 32'hFFFF_FFF8, exp_pc: '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4}};
    vecs[3] = '{target: 32'h0000_0007, exp_pc: '{32'h4, 32'h8, 32'hC, 32'h10}};

    sel = 1'b0;
    ready_x = 1'b1;
    flush_x = 1'b0;
    newpc_x = 32'h0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    check("rst_ce", {31'b0, obs_ce}, 32'h0);
    check("rst_addr", obs_addr, 32'h0);
    check("rst_valid", {31'b0, obs_valid}, 32'h0);
    check("rst_pc", obs_pc, 32'h0);
    check("rst_inst", obs_inst, 32'h0);

    // start-up, ROM_LAT=1
    @(posedge clk);
    #1 rst = 1'b1;
    popped.delete();
    wait_pops(6);
    check("start_first_valid_cycle", 32'(first_dut_valid), 32'd3);
    check_pops("start_seq", 32'h0, 6);

    // backpressure from start
    do_reset(1'b0, 1'b0);
    idle(10);
    check("bp_issues", 32'(dut_issues), 32'd4);
    check("bp_head_valid", {31'b0, obs_valid}, 32'h1);
    check("bp_head_pc", obs_pc, 32'h0);
    popped.delete();
    ready_x = 1'b1;
    wait_pops(8);
    check_pops("bp_release_seq", 32'h0, 8);

    // flush targets on both latencies
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0], 1'b1);
      idle(6);
      for (int v = 0; v < 4; v++) begin
        flush_to(vecs[v].target);
        wait_pops(4);
        for (int i = 0; i < 4; i++) begin
          if (i < popped.size()) check("flush_vec", popped[i], vecs[v].exp_pc[i]);
        end
        idle(2);
      end
    end

    // ROM_LAT=2 flush with two requests outstanding (issued cycles 1 and 2)
    do_reset(1'b1, 1'b1);
    idle(2);
    flush_to(32'h200);
    wait_pops(4);
    check_pops("lat2_inflight_flush", 32'h200, 4);

    // back-to-back flushes: the last target wins
    @(posedge clk);
    #1;
    flush_x = 1'b1;
    newpc_x = 32'h100;
    popped.delete();
    @(posedge clk);
    #1;
    newpc_x = 32'h300;
    @(posedge clk);
    #1;
    flush_x = 1'b0;
    wait_pops(3);
    check_pops("b2b_flush", 32'h300, 3);

    // asynchronous reset between clock edges
    do_reset(1'b0, 1'b1);
    idle(8);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_ce", {31'b0, obs_ce}, 32'h0);
    check("arst_addr", obs_addr, 32'h0);
    check("arst_valid", {31'b0, obs_valid}, 32'h0);
    check("arst_pc", obs_pc, 32'h0);
    check("arst_inst", obs_inst, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    popped.delete();
    wait_pops(3);
    check("arst_first_valid_cycle", 32'(first_dut_valid), 32'd3);
    check_pops("arst_restart", 32'h0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
